mem_arbiter: RTL

Two-port arbiter and sequencer in front of the single-ported DPI-backed `MEM` block. It shares the memory between the instruction fetch unit (read-only) and the load/store unit (read/write). Each requester gets a valid/ready request channel and a valid/ready response channel. The arbiter drives `MEM`'s combinational `addr/we/ce/wdata/wmask` port for exactly one cycle per transaction and registers the returned data.

---
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-way round-robin arbiter sharing the single MEM port
// between IFU and LSU; one ce pulse per transaction, registered response.
module mem_arbiter #(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [63:0] ifu_req_addr,
    output logic        ifu_resp_valid,
    input  logic        ifu_resp_ready,
    output logic [63:0] ifu_resp_data,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [63:0] lsu_req_addr,
    input  logic        lsu_req_we,
    input  logic [63:0] lsu_req_wdata,
    input  logic [7:0]  lsu_req_wmask,
    output logic        lsu_resp_valid,
    input  logic        lsu_resp_ready,
    output logic [63:0] lsu_resp_data,
    output logic [63:0] mem_addr,
    output logic        mem_ce,
    output logic        mem_we,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [63:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;
    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] rdata_q, rdata_d;
    logic        ce_q, ce_d;
    logic        we_q, we_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wmask_q, wmask_d;
    logic        ifu_rv_q, ifu_rv_d;
    logic        lsu_rv_q, lsu_rv_d;

    logic ifu_grant;
    logic lsu_grant;
    logic owner_ack;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        ifu_grant = ifu_req_valid
                  & (~lsu_req_valid | (last_grant_q == OWN_LSU));
        lsu_grant = lsu_req_valid
                  & (~ifu_req_valid | (last_grant_q == OWN_IFU));
        ifu_req_ready = (state_q == S_IDLE) & ifu_grant;
        lsu_req_ready = (state_q == S_IDLE) & lsu_grant;
        owner_ack = (owner_q == OWN_LSU) ? lsu_resp_ready
                                         : ifu_resp_ready;
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        ifu_rv_d     = ifu_rv_q;
        lsu_rv_d     = lsu_rv_q;
        ce_d         = 1'b0;
        we_d         = 1'b0;
        addr_d       = 64'h0;
        wdata_d      = 64'h0;
        wmask_d      = 8'h0;
        unique case (state_q)
            S_IDLE: begin
                if (ifu_req_ready || lsu_req_ready) begin
                    state_d      = S_ACCESS;
                    owner_d      = lsu_req_ready;
                    last_grant_d = lsu_req_ready;
                    cnt_d        = LAT;
                    ce_d         = 1'b1;
                    if (lsu_req_ready) begin
                        we_d    = lsu_req_we;
                        addr_d  = lsu_req_addr;
                        wdata_d = lsu_req_wdata;
                        wmask_d = lsu_req_wmask;
                    end else begin
                        addr_d  = ifu_req_addr;
                    end
                end
            end
            S_ACCESS: begin
                if (ce_q) begin
                    rdata_d = we_q ? 64'h0 : mem_rdata;
                end
                // A count of 0 is treated like 1 so the FSM cannot wrap.
                if (cnt_q <= 4'd1) begin
                    state_d  = S_RESP;
                    ifu_rv_d = (owner_q == OWN_IFU);
                    lsu_rv_d = (owner_q == OWN_LSU);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (owner_ack) begin
                    state_d  = S_IDLE;
                    ifu_rv_d = 1'b0;
                    lsu_rv_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_IFU;
            last_grant_q <= OWN_IFU;
            cnt_q        <= 4'h0;
            rdata_q      <= 64'h0;
            ce_q         <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 64'h0;
            wdata_q      <= 64'h0;
            wmask_q      <= 8'h0;
            ifu_rv_q     <= 1'b0;
            lsu_rv_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            ce_q         <= ce_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            ifu_rv_q     <= ifu_rv_d;
            lsu_rv_q     <= lsu_rv_d;
        end
    end

    assign mem_ce    = ce_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;

    assign ifu_resp_valid = ifu_rv_q;
    assign lsu_resp_valid = lsu_rv_q;
    assign ifu_resp_data  = ifu_rv_q ? rdata_q : 64'h0;
    assign lsu_resp_data  = lsu_rv_q ? rdata_q : 64'h0;

    assign busy = (state_q != S_IDLE);

endmodule
